// File: rtl/seq_mem_controller.sv
// -----------------------------------------------------------------------------
// seq_mem_controller
//   Master side of the PlaySeq sequence RAM. Records one-hot button presses
//   into the RAM and plays the stored sequence back on the LEDs. The RAM
//   registers its address, so read data is valid the cycle after ram_addr.
//
// Ports
//   clk       in   1         system clock, rising edge
//   reset     in   1         synchronous, active-high
//   record    in   1         pulse: start recording (idle) / stop recording
//   play      in   1         pulse: start playback of the stored sequence
//   buttons   in   DATA_W    synchronized button levels, 1 = pressed
//   ram_we    out  1         RAM write enable
//   ram_addr  out  ADDR_W    RAM address
//   ram_data  out  DATA_W    RAM write data
//   ram_q     in   DATA_W    RAM read data (valid 1 cycle after ram_addr)
//   leds      out  DATA_W    playback display
//   length    out  ADDR_W+1  number of stored steps, 0..2**ADDR_W
//   busy      out  1         high in every state except idle
//   done      out  1         one-cycle pulse when recording stops / playback ends
//
// Configuration
//   SEQ_PRELOAD_EN  when defined, reset sets length to the full RAM depth so
//                   play after reset replays the pre-programmed RAM image.
//                   When undefined, reset clears length to 0.
// -----------------------------------------------------------------------------
module seq_mem_controller #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int PLAY_TICKS = 1000,
  parameter int GAP_TICKS  = 250
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record,
  input  logic              play,
  input  logic [DATA_W-1:0] buttons,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] leds,
  output logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done
);

  localparam int TICK_MAX = (PLAY_TICKS > GAP_TICKS) ? PLAY_TICKS : GAP_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TICK_W-1:0] PLAY_LAST = TICK_W'(PLAY_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [ADDR_W:0]   LEN_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] BTN_ONE   = DATA_W'(1);

`ifdef SEQ_PRELOAD_EN
  localparam logic [ADDR_W:0]   LEN_RST   = LEN_FULL;
`else
  localparam logic [ADDR_W:0]   LEN_RST   = '0;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_REC_WAIT,
    S_REC_WRITE,
    S_REC_RELEASE,
    S_PLAY_ADDR,
    S_PLAY_LOAD,
    S_PLAY_SHOW,
    S_PLAY_GAP,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     index_q, index_d;    // one bit wider so index==LEN_FULL is reachable
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [ADDR_W:0]     length_q, length_d;
  logic                stop_q, stop_d;      // stop request seen during the write cycle
  logic [DATA_W-1:0]   prev_btn_q;

  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic [DATA_W-1:0]   leds_q, leds_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // A press counts only on the edge from all-released to exactly one button.
  logic press_valid;
  assign press_valid = (prev_btn_q == '0) && (buttons != '0) &&
                       ((buttons & (buttons - BTN_ONE)) == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers
    // update from the same pre-edge values, independent of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      tick_q     <= '0;
      length_q   <= LEN_RST;
      stop_q     <= 1'b0;
      prev_btn_q <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      leds_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      tick_q     <= tick_d;
      length_q   <= length_d;
      stop_q     <= stop_d;
      prev_btn_q <= buttons;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      leds_q     <= leds_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold default first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    index_d  = index_q;
    tick_d   = tick_q;
    length_d = length_q;
    stop_d   = stop_q;

    unique case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (record) begin
          state_d  = S_REC_WAIT;
          length_d = '0;
        end else if (play) begin
          state_d = S_PLAY_ADDR;
          index_d = '0;
        end
      end
      S_REC_WAIT: begin
        if (record)           state_d = S_FINISH;
        else if (press_valid) state_d = S_REC_WRITE;
      end
      S_REC_WRITE: begin
        length_d = length_q + LEN_ONE;
        if (record) stop_d = 1'b1;
        state_d = S_REC_RELEASE;
      end
      S_REC_RELEASE: begin
        if (record || stop_q)     state_d = S_FINISH;
        else if (buttons == '0)   state_d = (length_q == LEN_FULL) ? S_FINISH : S_REC_WAIT;
      end
      S_PLAY_ADDR: begin
        state_d = (index_q == length_q) ? S_FINISH : S_PLAY_LOAD;
      end
      S_PLAY_LOAD: begin
        state_d = S_PLAY_SHOW;
        tick_d  = '0;
      end
      S_PLAY_SHOW: begin
        if (tick_q == PLAY_LAST) begin
          state_d = S_PLAY_GAP;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      S_PLAY_GAP: begin
        if (tick_q == GAP_LAST) begin
          state_d = S_PLAY_ADDR;
          index_d = index_q + LEN_ONE;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      S_FINISH: begin
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, computed from the transition being taken
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we_d   = (state_d == S_REC_WRITE);
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);

    if (state_q == S_REC_WAIT && state_d == S_REC_WRITE) begin
      ram_addr_d = length_q[ADDR_W-1:0];
      ram_data_d = buttons;
    end

    // The address is launched as PLAY_ADDR is entered, so the RAM has sampled
    // it by the end of PLAY_ADDR and ram_q is valid throughout PLAY_LOAD.
    // Nothing is driven when the index has reached the stored length.
    if (state_d == S_PLAY_ADDR && index_d != length_d) begin
      ram_addr_d = index_d[ADDR_W-1:0];
    end

    if (state_d == S_PLAY_SHOW) begin
      leds_d = (state_q == S_PLAY_LOAD) ? ram_q : leds_q;
    end else begin
      leds_d = '0;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign leds     = leds_q;
  assign length   = length_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_seq_mem_controller
//   Scoreboard bench for seq_mem_controller (PLAY_TICKS=4, GAP_TICKS=2).
//   The stimulus process keeps an abstract model (mode, stored length, stored
//   words) and pushes every expected RAM write, LED step and done pulse into a
//   queue; the monitor pops and compares whenever the DUT shows one of them.
//   A registered-address RAM is modelled alongside the DUT.
// -----------------------------------------------------------------------------
module tb_seq_mem_controller;

  localparam int PLAY_T = 4;
  localparam int GAP_T  = 2;
  localparam int DEPTH  = 16;
`ifdef SEQ_PRELOAD_EN
  localparam int LEN_RST = DEPTH;
`else
  localparam int LEN_RST = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       record = 1'b0;
  logic       play = 1'b0;
  logic [3:0] buttons = '0;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [3:0] ram_data;
  logic [3:0] ram_q = '0;
  logic [3:0] leds;
  logic [4:0] length;
  logic       busy;
  logic       done;
  logic       ram_load = 1'b1;

  seq_mem_controller #(
    .ADDR_W(4), .DATA_W(4), .PLAY_TICKS(PLAY_T), .GAP_TICKS(GAP_T)
  ) dut (
    .clk(clk), .reset(reset), .record(record), .play(play), .buttons(buttons),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
    .leds(leds), .length(length), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Initial RAM image: one-hot words so every stored step lights an LED.
  function automatic logic [3:0] init_word(input int i);
    return 4'(1 << (i % 4));
  endfunction

  logic [3:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_data;
    end
    ram_q <= ram_mem[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef enum {EV_WRITE, EV_DONE, EV_LED} ev_kind_e;
  typedef struct { ev_kind_e kind; int a; int b; } ev_t;  // WRITE a=addr b=data, DONE a=len, LED a=index b=value
  typedef enum {M_IDLE, M_REC, M_PLAY} mode_e;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad   = 0;
  mode_e      mode  = M_IDLE;
  int         m_len = LEN_RST;
  logic [3:0] model_mem [DEPTH];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic pop(input ev_kind_e k, input string nm, output ev_t e, output bit ok);
    e  = '{EV_DONE, 0, 0};
    ok = 1'b0;
    check({nm, "_expected"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, 32'(e.kind), 32'(k));
      ok = (e.kind == k);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin : monitor
    ev_t        e;
    bit         ok;
    bit         in_seg = 0, after_seg = 0;
    int         lit = 0, dark = 0;
    logic [3:0] cur = '0, a1 = '0, a2 = '0, seg_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_seg = 0;
        after_seg = 0;
      end else begin
        if (ram_we) begin
          pop(EV_WRITE, "write", e, ok);
          if (ok) begin
            check("write_addr", 32'(ram_addr), 32'(e.a));
            check("write_data", 32'(ram_data), 32'(e.b));
          end
        end
        if (done) begin
          pop(EV_DONE, "done", e, ok);
          if (ok) check("done_length", 32'(length), 32'(e.a));
          after_seg = 0;
        end
        if (in_seg && leds != cur) begin
          pop(EV_LED, "led", e, ok);
          if (ok) begin
            check("led_addr", 32'(seg_addr), 32'(e.a));
            check("led_value", 32'(cur), 32'(e.b));
            check("led_lit_cycles", 32'(lit), 32'(PLAY_T));
          end
          in_seg = 0;
          after_seg = 1;
          dark = 0;
        end else if (in_seg) begin
          lit++;
        end
        if (!in_seg && leds == '0 && after_seg) begin
          dark++;
        end else if (!in_seg && leds != '0) begin
          // Between steps: GAP cycles plus the PLAY_ADDR and PLAY_LOAD cycles.
          if (after_seg) check("led_dark_cycles", 32'(dark), 32'(GAP_T + 2));
          in_seg = 1;
          cur = leds;
          lit = 1;
          seg_addr = a2;  // address launched two cycles before the LEDs changed
          after_seg = 0;
        end
      end
      a2 = a1;
      a1 = ram_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus with abstract model
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 400);
    check("idle_wait", 32'(busy), 32'd0);
    if (mode == M_PLAY) mode = M_IDLE;
  endtask

  // Effect of a record pulse on the model.
  task automatic model_record();
    case (mode)
      M_IDLE: begin
        mode  = M_REC;
        m_len = 0;
      end
      M_REC: begin
        exp_q.push_back('{EV_DONE, m_len, 0});
        mode = M_IDLE;
      end
      default: ;
    endcase
  endtask

  task automatic start_record();
    wait_idle();
    record = 1'b1;
    model_record();
    tick();
    record = 1'b0;
  endtask

  task automatic stop_record();
    record = 1'b1;
    model_record();
    tick();
    record = 1'b0;
  endtask

  task automatic start_play();
    wait_idle();
    for (int i = 0; i < m_len; i++) exp_q.push_back('{EV_LED, i, 32'(model_mem[i])});
    exp_q.push_back('{EV_DONE, m_len, 0});
    mode = M_PLAY;
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask

  // Press v for hold cycles, then release for rel (>=2) cycles. With
  // stop_in_write a record pulse lands on the second held cycle.
  task automatic press(input logic [3:0] v, input int hold, input int rel, input bit stop_in_write);
    bit wrote = 0;
    if (mode == M_REC && $countones(v) == 1 && m_len < DEPTH) begin
      exp_q.push_back('{EV_WRITE, m_len, 32'(v)});
      model_mem[m_len] = v;
      m_len++;
      wrote = 1;
    end
    buttons = v;
    tick();
    for (int i = 1; i < hold; i++) begin
      if (i == 1 && stop_in_write) begin
        record = 1'b1;
        model_record();
      end
      tick();
      record = 1'b0;
    end
    buttons = '0;
    if (mode == M_REC && wrote && m_len == DEPTH) begin
      exp_q.push_back('{EV_DONE, m_len, 0});
      mode = M_IDLE;
    end
    repeat (rel) tick();
  endtask

  function automatic logic [3:0] rand_onehot();
    return 4'(1 << $urandom_range(0, 3));
  endfunction

  initial begin : stimulus
    int n;
    logic [3:0] v;
    bit siw;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    ram_load = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_data", 32'(ram_data), 32'd0);
    check("rst_length", 32'(length), 32'(LEN_RST));

    // Record two presses and stop, then play them back
    start_record();
    press(4'b0001, 2, 2, 0);
    press(4'b0100, 2, 2, 0);
    stop_record();
    wait_idle();
    check("rec2_length", 32'(length), 32'd2);
    start_play();
    wait_idle();

    // Multi-bit press ignored; a long hold writes once
    start_record();
    press(4'b0011, 1, 2, 0);
    press(4'b1000, 10, 2, 0);
    stop_record();
    wait_idle();
    check("hold_length", 32'(length), 32'd1);
    start_play();
    wait_idle();

    // Fill the RAM: auto stop at 16, 17th press ignored
    start_record();
    for (int k = 0; k < DEPTH; k++) press(rand_onehot(), $urandom_range(1, 3), 2, 0);
    press(4'b0010, 2, 3, 0);
    wait_idle();
    check("full_length", 32'(length), 32'd16);
    start_play();
    wait_idle();

    // record and play together in idle: recording wins
    wait_idle();
    record = 1'b1;
    play = 1'b1;
    model_record();
    tick();
    record = 1'b0;
    play = 1'b0;
    check("both_length", 32'(length), 32'd0);
    check("both_busy", 32'(busy), 32'd1);
    press(4'b0010, 2, 2, 0);
    stop_record();
    wait_idle();
    check("both_after_length", 32'(length), 32'd1);

    // Randomized sessions
    for (int r = 0; r < 8; r++) begin
      start_record();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        v = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : rand_onehot();
        siw = (k == n - 1) && ($urandom_range(0, 1) == 1);
        press(v, siw ? $urandom_range(2, 4) : $urandom_range(1, 4), $urandom_range(2, 3), siw);
        if (mode != M_REC) break;
        if ($urandom_range(0, 4) == 0) begin
          play = 1'b1;  // ignored while recording
          tick();
          play = 1'b0;
        end
      end
      if (mode == M_REC) stop_record();
      start_play();
      if (m_len > 0 && $urandom_range(0, 1) == 1) begin
        tick();
        record = 1'b1;  // ignored while playing
        tick();
        record = 1'b0;
      end
      wait_idle();
    end

    // Reset in the middle of a displayed step
    start_record();
    press(4'b0100, 2, 2, 0);
    press(4'b0001, 2, 2, 0);
    stop_record();
    start_play();
    n = 0;
    while (leds == '0 && n < 100) begin
      tick();
      n++;
    end
    check("show_reached", 32'(leds != '0), 32'd1);
    tick();
    reset = 1'b1;
    exp_q.delete();
    mode  = M_IDLE;
    m_len = LEN_RST;
    tick();
    reset = 1'b0;
    check("midrst_leds", 32'(leds), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_we", 32'(ram_we), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_length", 32'(length), 32'(LEN_RST));

    // Play straight after reset
    start_play();
    wait_idle();

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
